// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width defaults, the NOP encoding and the
// {pc, inst} pair carried by the fetch-to-decode instruction queue.
package cpu_pkg;

  localparam int INST_W = 32;
  localparam int PC_W   = 32;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } iq_entry_t;

endpackage

// File: rtl/id_iq_ram.sv
// Storage array for the instruction queue: one synchronous write port and
// one asynchronous (combinational) read port.
module id_iq_ram #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset; validity is tracked by the pointers, so
  // resetting it would only add a wide reset tree with no functional effect.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/id_inst_queue.sv
// Instruction queue between the instruction SRAM response and the ID stage,
// with flush on branch redirect. Optional macro ID_BYPASS_EN enables a
// zero-latency path from the SRAM response to ID when the queue is empty.
module id_inst_queue #(
  parameter int DEPTH  = 4,
  parameter int INST_W = cpu_pkg::INST_W,
  parameter int PC_W   = cpu_pkg::PC_W,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              in_ready,
  output logic              out_valid,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              overflow_err
);

  localparam int AW = CNT_W - 1;

  logic [CNT_W-1:0]       wptr, rptr;
  logic                   push, pop, bypass;
  logic [PC_W+INST_W-1:0] rd_data;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full     = (wptr ^ rptr) == {1'b1, {AW{1'b0}}};
  assign empty    = (wptr == rptr);
  assign count    = wptr - rptr;
  assign in_ready = ~full;

`ifdef ID_BYPASS_EN
  assign bypass = empty & in_valid & out_ready & ~flush;
`else
  assign bypass = 1'b0;
`endif

  assign push = in_valid & in_ready & ~flush & ~bypass;
  assign pop  = ~empty & out_ready & ~flush;

  id_iq_ram #(
    .DEPTH (DEPTH),
    .WIDTH (PC_W + INST_W)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wptr[AW-1:0]),
    .wdata ({in_pc, in_inst}),
    .raddr (rptr[AW-1:0]),
    .rdata (rd_data)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr         <= '0;
      rptr         <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (in_valid & full) overflow_err <= 1'b1;
      if (flush) begin
        rptr <= wptr;
      end else begin
        if (push) wptr <= wptr + 1'b1;
        if (pop)  rptr <= rptr + 1'b1;
      end
    end
  end

  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    out_valid = 1'b0;
    out_pc    = '0;
    out_inst  = INST_W'(cpu_pkg::NOP_INST);
    if (!flush) begin
      if (bypass) begin
        out_valid = 1'b1;
        out_pc    = in_pc;
        out_inst  = in_inst;
      end else if (!empty) begin
        out_valid = 1'b1;
        {out_pc, out_inst} = rd_data;
      end
    end
  end

endmodule

// File: tb/tb_id_inst_queue.sv
// Self-checking bench for id_inst_queue: directed scenarios plus a random run,
// all compared against a queue-based behavioural model.
module tb_id_inst_queue;
  import cpu_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef ID_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              resetn, flush, in_valid, out_ready;
  logic [PC_W-1:0]   in_pc;
  logic [INST_W-1:0] in_inst;
  logic              in_ready, out_valid, full, empty, overflow_err;
  logic [PC_W-1:0]   out_pc;
  logic [INST_W-1:0] out_inst;
  logic [CNT_W-1:0]  count;

  id_inst_queue #(.DEPTH(DEPTH), .INST_W(INST_W), .PC_W(PC_W)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_pc        (in_pc),
    .in_inst      (in_inst),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_pc       (out_pc),
    .out_inst     (out_inst),
    .out_ready    (out_ready),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  iq_entry_t q[$];
  bit        m_ovf;
  int        n_checks = 0;
  int        n_fail   = 0;
  logic      exp_valid;
  iq_entry_t exp_head;

  // Apply inputs just after a falling edge and derive the expected
  // combinational view from the model.
  task automatic drive(input logic fl, input logic iv, input logic [PC_W-1:0] pc,
                       input logic [INST_W-1:0] inst, input logic ordy);
    flush = fl; in_valid = iv; in_pc = pc; in_inst = inst; out_ready = ordy;
    #1;
    exp_valid = 1'b0;
    exp_head  = '0;
    if (!fl) begin
      if (q.size() > 0) begin
        exp_valid = 1'b1;
        exp_head  = q[0];
      end else if (BYP && iv && ordy) begin
        exp_valid = 1'b1;
        exp_head  = '{pc, inst};
      end
    end
  endtask

  // Advance one clock and apply the queue rules to the model.
  task automatic tick();
    bit byp, do_pop, do_push;
    @(posedge clk);
    if (in_valid && q.size() == DEPTH) m_ovf = 1'b1;
    if (flush) begin
      q.delete();
    end else begin
      byp     = BYP && q.size() == 0 && in_valid && out_ready;
      do_pop  = q.size() > 0 && out_ready;
      do_push = in_valid && q.size() < DEPTH && !byp;
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back('{in_pc, in_inst});
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(0, 0, '0, '0, 0);
    n_checks++; if (out_valid !== 1'b0 || empty !== 1'b1 || in_ready !== 1'b1 || full !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: valid=%b empty=%b in_ready=%b full=%b want 0 1 1 0", out_valid, empty, in_ready, full);
    end
    n_checks++; if (out_pc !== '0 || out_inst !== NOP_INST) begin
      n_fail++; $display("FAIL reset_data: pc=%h inst=%h want 0 0", out_pc, out_inst);
    end
    resetn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 32'h100 + 4 * i, $urandom, 0);
      tick();
    end
    #2 resetn = 1'b0;
    #1;
    q.delete();
    m_ovf = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || empty !== 1'b1 || count !== '0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid: valid=%b empty=%b count=%0d in_ready=%b want 0 1 0 1", out_valid, empty, count, in_ready);
    end
    @(negedge clk);
    resetn = 1'b1;
    drive(0, 1, 32'hBFC0_0000, 32'h3408_0001, 0);
    tick();
    drive(0, 0, '0, '0, 0);
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'hBFC0_0000 || out_inst !== 32'h3408_0001) begin
      n_fail++; $display("FAIL reset_first_push: valid=%b pc=%h inst=%h want 1 bfc00000 34080001", out_valid, out_pc, out_inst);
    end
    drive(0, 0, '0, '0, 1);
    tick();
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 32'h2000 + 4 * i, $urandom, 0);
      if (i == 4) begin
        n_checks++; if (full !== 1'b1 || in_ready !== 1'b0 || count !== CNT_W'(DEPTH)) begin
          n_fail++; $display("FAIL fill_full: full=%b in_ready=%b count=%0d want 1 0 %0d", full, in_ready, count, DEPTH);
        end
        n_checks++; if (overflow_err !== 1'b0) begin
          n_fail++; $display("FAIL fill_ovf_early: got %b want 0", overflow_err);
        end
      end
      tick();
    end
    drive(0, 0, '0, '0, 0);
    n_checks++; if (overflow_err !== 1'b1 || count !== CNT_W'(DEPTH)) begin
      n_fail++; $display("FAIL fill_overflow: ovf=%b count=%0d want 1 %0d", overflow_err, count, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 0, '0, '0, 1);
      n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h2000 + 4 * i || out_inst !== exp_head.inst) begin
        n_fail++; $display("FAIL drain_order[%0d]: valid=%b pc=%h inst=%h want 1 %h %h", i, out_valid, out_pc, out_inst, 32'h2000 + 4 * i, exp_head.inst);
      end
      tick();
    end
    drive(0, 0, '0, '0, 0);
    n_checks++; if (empty !== 1'b1 || overflow_err !== 1'b1) begin
      n_fail++; $display("FAIL drain_end: empty=%b ovf=%b want 1 1", empty, overflow_err);
    end
  endtask

  task automatic test_stall_hold();
    logic [PC_W-1:0] pc0;
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 32'h3000 + 4 * i, $urandom, 0);
      tick();
    end
    pc0 = 32'h3000;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, '0, '0, 0);
      n_checks++; if (out_valid !== 1'b1 || out_pc !== pc0 || out_inst !== exp_head.inst) begin
        n_fail++; $display("FAIL stall_hold[%0d]: valid=%b pc=%h inst=%h want 1 %h %h", i, out_valid, out_pc, out_inst, pc0, exp_head.inst);
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, '0, '0, 1);
      n_checks++; if (count !== CNT_W'(2 - i)) begin
        n_fail++; $display("FAIL stall_drain_count[%0d]: got %0d want %0d", i, count, 2 - i);
      end
      if (i < 2) begin
        n_checks++; if (out_pc !== 32'h3000 + 4 * i) begin
          n_fail++; $display("FAIL stall_drain_pc[%0d]: got %h want %h", i, out_pc, 32'h3000 + 4 * i);
        end
      end
      tick();
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 32'h4000 + 4 * i, $urandom, 0);
      tick();
    end
    drive(1, 1, 32'h4444, 32'h5555, 1);
    n_checks++; if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_valid: got %b want 0", out_valid);
    end
    tick();
    drive(0, 0, '0, '0, 0);
    n_checks++; if (count !== '0 || empty !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_after: count=%0d empty=%b valid=%b want 0 1 0", count, empty, out_valid);
    end
  endtask

  task automatic test_concurrent();
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 32'h5000 + 4 * i, $urandom, 0);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 32'h5008 + 4 * i, $urandom, 1);
      n_checks++; if (count !== CNT_W'(2) || out_pc !== 32'h5000 + 4 * i || out_inst !== exp_head.inst) begin
        n_fail++; $display("FAIL concurrent[%0d]: count=%0d pc=%h inst=%h want 2 %h %h", i, count, out_pc, out_inst, 32'h5000 + 4 * i, exp_head.inst);
      end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, '0, '0, 1);
      tick();
    end
  endtask

  task automatic test_bypass();
    drive(0, 1, 32'h6000, 32'h2402_0005, 1);
    n_checks++; if (out_valid !== exp_valid || (BYP && out_inst !== 32'h2402_0005)) begin
      n_fail++; $display("FAIL bypass_same_cycle: valid=%b inst=%h want %b 24020005", out_valid, out_inst, exp_valid);
    end
    tick();
    drive(0, 0, '0, '0, 0);
    n_checks++; if (count !== CNT_W'(q.size()) || out_valid !== exp_valid) begin
      n_fail++; $display("FAIL bypass_next: count=%0d valid=%b want %0d %b", count, out_valid, q.size(), exp_valid);
    end
    if (!BYP) begin
      n_checks++; if (out_inst !== 32'h2402_0005) begin
        n_fail++; $display("FAIL bypass_latency: inst=%h want 24020005", out_inst);
      end
    end
    drive(0, 0, '0, '0, 1);
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 6), $urandom, $urandom,
            ($urandom_range(0, 1) == 1));
      n_checks++; if (out_valid !== exp_valid || (exp_valid && (out_pc !== exp_head.pc || out_inst !== exp_head.inst))) begin
        n_fail++; $display("FAIL random_out[%0d]: valid=%b pc=%h inst=%h want %b %h %h", i, out_valid, out_pc, out_inst, exp_valid, exp_head.pc, exp_head.inst);
      end
      n_checks++; if (count !== CNT_W'(q.size()) || full !== (q.size() == DEPTH) || empty !== (q.size() == 0) || in_ready !== (q.size() != DEPTH) || overflow_err !== m_ovf) begin
        n_fail++; $display("FAIL random_state[%0d]: count=%0d full=%b empty=%b in_ready=%b ovf=%b want count=%0d ovf=%b", i, count, full, empty, in_ready, overflow_err, q.size(), m_ovf);
      end
      tick();
    end
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_inst = '0; m_ovf = 1'b0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_fill_drain();
    test_stall_hold();
    test_flush();
    test_concurrent();
    test_bypass();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
